// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_pkg                                                                  |
// | Shared operation encoding, FSM state type and op-decode helpers for the  |
// | multiply/divide unit.                                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  // Divide ops have op[1] set.
  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  // Signed ops (MULT, DIV) have op[0] clear.
  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_datapath                                                             |
// | Unsigned iterative engine: one shift-add (multiply) or one restoring     |
// | shift-subtract (divide) step per cycle, plus the iteration counter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mdu_datapath #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             last
);

  localparam int CW = $clog2(ITERS + 1);

  // acc holds {upper, lower}: product-high/multiplier for multiply,
  // remainder/quotient (dividend shifting out) for divide.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m_r;      // multiplicand or divisor magnitude
  logic               div_r;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_r} : '0);
    div_shift = {acc, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, m_r};
    if (div_r) begin
      // Negative trial means restore: keep the shifted value, quotient bit 0.
      if (div_trial[WIDTH]) acc_next = div_shift[2*WIDTH-1:0];
      else                  acc_next = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Operand capture on load, one step per cycle while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      m_r   <= '0;
      div_r <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      m_r   <= is_div ? mag_b : mag_a;
      div_r <= is_div;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

  assign last   = (count == CW'(ITERS - 1));
  assign res_hi = acc[2*WIDTH-1:WIDTH];
  assign res_lo = acc[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_unit                                                            |
// | MIPS-style HI/LO multiply/divide unit: control FSM, sign handling,       |
// | divide-by-zero result and the architectural HI/LO registers.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  mdu_state_t state, next_state;
  logic             load, step, last;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             sa, sb;
  logic [2*WIDTH-1:0] prod_fix;

  // Magnitudes of the incoming operands; only meaningful on the load cycle.
  always_comb begin
    mag_a = (op_is_signed(op) && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b = (op_is_signed(op) && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  end

  mdu_datapath #(.WIDTH(WIDTH), .ITERS(ITERS)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (op_is_div(op)),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and control decode; start is only honoured in IDLE/DONE.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) next_state = ST_FIX;
      end
      ST_FIX: begin
        busy       = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Keep the raw operands and op for sign correction and the /0 result.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= OP_MULT;
      a_r  <= '0;
      b_r  <= '0;
    end else if (load) begin
      op_r <= op;
      a_r  <= operand_a;
      b_r  <= operand_b;
    end
  end

  // Sign correction of the unsigned engine result, evaluated during FIX.
  always_comb begin
    sa       = op_is_signed(op_r) & a_r[WIDTH-1];
    sb       = op_is_signed(op_r) & b_r[WIDTH-1];
    prod_fix = (sa ^ sb) ? -{res_hi, res_lo} : {res_hi, res_lo};
    if (!op_is_div(op_r)) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (b_r == '0) begin
      fix_hi = a_r;
      fix_lo = '1;
    end else begin
      fix_hi = sa ? -res_hi : res_hi;
      fix_lo = (sa ^ sb) ? -res_lo : res_lo;
    end
  end

  // HI/LO: result on FIX->DONE, MTHI/MTLO only when idle and not starting.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (!busy && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_div_unit                                                         |
// | Directed-vector bench with an expected-result queue drained by a monitor |
// | on every done pulse.                                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 2;

  logic             clk = 1'b0;
  logic             reset, start, hi_we, lo_we, busy, done;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a, operand_b, wdata, hi, lo;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    int               id;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_count  = 0;
  int   dc0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(WIDTH), .ITERS(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 with nothing pending, hi=%h lo=%h expected no pulse", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("op%0d_hi", e.id), hi, e.hi);
        check($sformatf("op%0d_lo", e.id), lo, e.lo);
      end
    end
  end

  // Issue one operation from a negedge and wait for its done pulse; checks
  // latency, busy window and HI/LO hold. Optionally injects a second start
  // (plus an MTHI) mid-flight, or an MTHI/MTLO colliding with the start.
  task automatic run_op(input int id, input logic [1:0] o,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                        input int inj_cycle, input logic collide_we);
    logic [WIDTH-1:0] hold_hi, hold_lo;
    int cnt      = 0;
    int bad_busy = 0;
    int bad_hold = 0;
    hold_hi = hi;
    hold_lo = lo;
    sb_q.push_back('{hi: eh, lo: el, id: id});
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    if (collide_we) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    end
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (inj_cycle != 0 && cnt == inj_cycle) begin
        start = 1'b1; op = OP_MULT; operand_a = 9; operand_b = 9;
        hi_we = 1'b1; wdata = 32'h0BAD0BAD;
      end
      if (inj_cycle != 0 && cnt == inj_cycle + 1) begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (cnt < LATENCY) begin
        if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
        if (hi !== hold_hi || lo !== hold_lo) bad_hold++;
      end
    end while (done !== 1'b1 && cnt < 100);
    check($sformatf("op%0d_latency", id), WIDTH'(cnt), WIDTH'(LATENCY));
    check($sformatf("op%0d_busy_window_errors", id), WIDTH'(bad_busy), '0);
    check($sformatf("op%0d_hilo_hold_errors", id), WIDTH'(bad_hold), '0);
    check($sformatf("op%0d_busy_at_done", id), WIDTH'(busy), '0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULT; operand_a = '0; operand_b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", WIDTH'(busy), '0);
    check("reset_done", WIDTH'(done), '0);

    // MTHI/MTLO in IDLE
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h13579BDF;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi_idle", hi, 32'hAAAA5555);
    check("mtlo_idle", lo, 32'h13579BDF);

    // Directed vectors; each after the first starts from DONE (back-to-back).
    run_op(1,  OP_MULT,  32'd6,        32'd7,        32'h00000000, 32'h0000002A, 0, 1'b0);
    run_op(2,  OP_MULT,  32'hFFFFFFFA, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFD6, 0, 1'b1);
    run_op(3,  OP_MULTU, 32'hFFFFFFFA, 32'd7,        32'h00000006, 32'hFFFFFFD6, 0, 1'b0);
    run_op(4,  OP_DIVU,  32'd8,        32'd6,        32'h00000002, 32'h00000001, 0, 1'b0);
    run_op(5,  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
    run_op(6,  OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 0, 1'b0);
    run_op(7,  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b0);
    run_op(8,  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0, 1'b0);
    run_op(9,  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 1'b0);
    run_op(10, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b0);
    run_op(11, OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Second start (9 x 9) and an MTHI while busy must both be ignored.
    dc0 = done_count;
    run_op(12, OP_MULT, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 10, 1'b0);
    repeat (40) @(negedge clk);
    check("busy_start_single_done", WIDTH'(done_count - dc0), 32'd1);
    check("busy_start_hi_kept", hi, 32'h00000000);
    check("busy_start_lo_kept", lo, 32'h0000002A);

    // Reset in the middle of a DIV: no done, HI/LO cleared.
    dc0 = done_count;
    op = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop_reset_busy", WIDTH'(busy), '0);
    check("midop_reset_hi", hi, '0);
    check("midop_reset_lo", lo, '0);
    repeat (40) @(negedge clk);
    check("midop_reset_no_done", WIDTH'(done_count - dc0), '0);
    check("midop_reset_busy_later", WIDTH'(busy), '0);
    lo_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_after_reset_lo", lo, 32'h00001234);
    check("mtlo_after_reset_hi", hi, '0);

    repeat (3) @(negedge clk);
    check("pending_results_left", WIDTH'(sb_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter ITERS, default WIDTH, number of RUN cycles; fixed equal to WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to launch an operation.
REQ-006 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port operand_a  input  WIDTH  rs read data from the register file (multiplicand or dividend).
REQ-008 SHALL have port operand_b  input  WIDTH  rt read data from the register file (multiplier or divisor).
REQ-009 SHALL have port hi_we  input  1  MTHI strobe.
REQ-010 SHALL have port lo_we  input  1  MTLO strobe.
REQ-011 SHALL have port wdata  input  WIDTH  MTHI/MTLO data.
REQ-012 SHALL have port hi  output  WIDTH  HI register (MFHI source).
REQ-013 SHALL have port lo  output  WIDTH  LO register (MFLO source).
REQ-014 SHALL have port busy  output  1  high in RUN and FIX.
REQ-015 SHALL have port done  output  1  one-cycle pulse; hi/lo hold the new result.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-017 SHALL accept start only in IDLE or DONE; it latches op and operands and enters RUN.
REQ-018 SHALL ignore start while busy; the operation in flight completes unchanged.
REQ-019 SHALL stay in RUN exactly WIDTH cycles, doing one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle.
REQ-020 SHALL perform the signed ops on magnitudes: product sign = sign_a XOR sign_b; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
REQ-021 SHALL apply the sign correction in FIX (1 cycle) and write hi/lo on the FIX->DONE edge.
REQ-022 SHALL hold DONE for 1 cycle with done=1, then go to IDLE, or to RUN if start is asserted.
REQ-023 SHALL raise done at the (WIDTH+2)th rising edge after the edge that samples start; for WIDTH=32, done is high in cycle 34.
REQ-024 SHALL produce a multiply result of {hi,lo} = full 2*WIDTH-bit product.
REQ-025 SHALL produce a divide result of lo = quotient and hi = remainder, both truncated toward zero.
REQ-026 SHALL handle divide by zero with normal latency and give lo = all ones and hi = operand_a.
REQ-027 SHALL return DIV 0x80000000 / 0xFFFFFFFF as lo = 0x80000000, hi = 0, with no exception.
REQ-028 SHALL apply hi_we/lo_we in IDLE or DONE on the next edge, and ignore them while busy.
REQ-029 SHALL give start priority when start and hi_we/lo_we occur in the same cycle; the MTHI/MTLO write is dropped.
REQ-030 SHALL keep hi/lo stable, holding the previous values, throughout RUN and FIX.

Reset
REQ-031 SHALL on reset go to IDLE and clear hi, lo, busy, done, the iteration counter and the internal accumulators to 0.
REQ-032 SHALL abort any operation in flight when reset occurs mid-operation, with no done pulse and hi/lo = 0.
REQ-033 SHALL give reset priority over start, hi_we and lo_we.

Structure
REQ-034 SHALL place the op encoding (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum in shared package mdu_pkg.
REQ-035 SHALL keep the per-cycle iteration step (shift-add / shift-subtract, counter) in one sub-module, mdu_datapath; the FSM, sign handling and HI/LO stay in mult_div_unit.

Verification
REQ-036 SHALL cover MULT 6 x 7: lo=42, hi=0, done in cycle 34, busy high for cycles 1-33.
REQ-037 SHALL cover MULT 0xFFFFFFFA x 7: lo=0xFFFFFFD6, hi=0xFFFFFFFF. It SHALL also cover MULTU with the same operands: hi=6, lo=0xFFFFFFD6.
REQ-038 SHALL cover DIVU 8 / 6: lo=1, hi=2. It SHALL also cover DIV 0xFFFFFFF9 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 SHALL cover DIVU 7 / 0: lo=0xFFFFFFFF, hi=7. It SHALL also cover DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-040 SHALL cover a second start with operands 9 x 9 at cycle 10 of a running 6 x 7 MULT: result stays 42, and no second done occurs.
REQ-041 SHALL cover reset at cycle 15 of a DIV: busy=0, done never pulses, hi=lo=0. A following MTLO of 0x1234 in IDLE SHALL give lo=0x1234 next cycle.
